simmem_delay_releaser: RTL and testbench

SIMMEM_DELAY_RELEASER -- requirements
Module: simmem_delay_releaser

---
 rtl/simmem_pkg.sv | 20 ++
 rtl/simmem_delay_slot.sv | 51 +++++
 rtl/simmem_delay_releaser.sv | 126 ++++++++++++
 tb/tb_simmem_delay_releaser.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared defaults and types for the simulated-memory delay releaser.
//   DefIdWidth    : default transaction ID width
//   DefNumSlots   : default number of concurrent delay slots
//   DefDelayWidth : default per-request delay width, in cycles
//   DefCntWidth   : default width of each per-ID expired counter
//   slot_state_t  : one delay slot's state {busy, id, counter}
package simmem_pkg;

    localparam int DefIdWidth    = 4;
    localparam int DefNumSlots   = 8;
    localparam int DefDelayWidth = 8;
    localparam int DefCntWidth   = 6;

    typedef struct packed {
        logic                     busy;
        logic [DefIdWidth-1:0]    id;
        logic [DefDelayWidth-1:0] counter;
    } slot_state_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// One delay slot: loads {id, delay}, counts down to zero, then raises
// expire_o for one cycle and returns to idle on the following edge.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture id_i/delay_i (only asserted while idle)
//   id_i, delay_i : request ID and delay
//   busy_o        : registered occupancy
//   id_o          : ID held by the slot
//   expire_o      : busy with counter == 0 this cycle
module simmem_delay_slot
    import simmem_pkg::*;
#(
    parameter int IDWidth    = DefIdWidth,
    parameter int DelayWidth = DefDelayWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [IDWidth-1:0]    id_i,
    input  logic [DelayWidth-1:0] delay_i,
    output logic                  busy_o,
    output logic [IDWidth-1:0]    id_o,
    output logic                  expire_o
);

    // Same layout as slot_state_t, sized by this instance's parameters.
    typedef struct packed {
        logic                  busy;
        logic [IDWidth-1:0]    id;
        logic [DelayWidth-1:0] counter;
    } state_t;

    state_t state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
        end else if (load_i) begin
            state_q.busy    <= 1'b1;
            state_q.id      <= id_i;
            state_q.counter <= delay_i;
        end else if (state_q.busy) begin
            if (state_q.counter == '0) state_q.busy <= 1'b0;
            else                       state_q.counter <= state_q.counter - 1'b1;
        end
    end

    assign busy_o   = state_q.busy;
    assign id_o     = state_q.id;
    assign expire_o = state_q.busy && (state_q.counter == '0);

endmodule

// File: rtl/simmem_delay_releaser.sv
// Delays incoming requests by a per-request cycle count and then grants
// per-ID release permission to the linked-list bank by counting expired
// entries per ID. Which slot produced a release is not tracked.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   req_valid_i/ready_o : delay request handshake (ready = any idle slot)
//   req_id_i, req_delay_i : request ID and delay
//   rel_done_i, rel_done_id_i : bank released one message of that ID
//   release_en_o        : per-ID release enable (expired count != 0)
//   busy_slots_o        : number of occupied slots
//   err_o               : sticky underflow/overflow error
module simmem_delay_releaser
    import simmem_pkg::*;
#(
    parameter int IDWidth    = DefIdWidth,
    parameter int NumSlots   = DefNumSlots,
    parameter int DelayWidth = DefDelayWidth,
    parameter int CntWidth   = DefCntWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [IDWidth-1:0]            req_id_i,
    input  logic [DelayWidth-1:0]         req_delay_i,
    input  logic                          rel_done_i,
    input  logic [IDWidth-1:0]            rel_done_id_i,
    output logic [2**IDWidth-1:0]         release_en_o,
    output logic [$clog2(NumSlots+1)-1:0] busy_slots_o,
    output logic                          err_o
);

    localparam int NumIds = 2**IDWidth;
    localparam int BusyW  = $clog2(NumSlots+1);
    // Wide enough for count + all slots expiring at once, before clamping.
    localparam int SumW   = CntWidth + BusyW + 1;
    localparam logic [SumW-1:0] CntMax = {{(SumW-CntWidth){1'b0}}, {CntWidth{1'b1}}};

    logic [NumSlots-1:0]              busy, expire, load;
    logic [NumSlots-1:0][IDWidth-1:0] slot_id;

    logic [NumIds-1:0][CntWidth-1:0]  exp_cnt_q, exp_cnt_d;
    logic [NumIds-1:0]                release_en_q;
    logic                             err_q, err_d;

    // Lowest-index idle slot, based on registered occupancy only: a slot
    // expiring this cycle still reads busy and is reused on the next edge.
    always_comb begin
        logic found;
        found = 1'b0;
        load  = '0;
        for (int s = 0; s < NumSlots; s++) begin
            if (!busy[s] && !found) begin
                load[s] = req_valid_i;
                found   = 1'b1;
            end
        end
    end

    assign req_ready_o = ~&busy;

    for (genvar s = 0; s < NumSlots; s++) begin : g_slot
        simmem_delay_slot #(
            .IDWidth    (IDWidth),
            .DelayWidth (DelayWidth)
        ) u_slot (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .load_i   (load[s]),
            .id_i     (req_id_i),
            .delay_i  (req_delay_i),
            .busy_o   (busy[s]),
            .id_o     (slot_id[s]),
            .expire_o (expire[s])
        );
    end

    // Per-ID net update: +k expiries, -1 on a release of that ID.
    // Decrement below zero clamps at 0; sums above CntMax saturate.
    always_comb begin
        logic [BusyW-1:0] k;
        logic [SumW-1:0]  sum;
        err_d     = err_q;
        exp_cnt_d = exp_cnt_q;
        k         = '0;
        sum       = '0;
        for (int i = 0; i < NumIds; i++) begin
            k = '0;
            for (int s = 0; s < NumSlots; s++) begin
                if (expire[s] && (slot_id[s] == IDWidth'(i))) k = k + BusyW'(1);
            end
            sum = SumW'(exp_cnt_q[i]) + SumW'(k);
            if (rel_done_i && (rel_done_id_i == IDWidth'(i))) begin
                if (sum == '0) err_d = 1'b1;
                else           sum   = sum - SumW'(1);
            end
            if (sum > CntMax) begin
                exp_cnt_d[i] = '1;
                err_d        = 1'b1;
            end else begin
                exp_cnt_d[i] = sum[CntWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_cnt_q    <= '0;
            release_en_q <= '0;
            err_q        <= 1'b0;
        end else begin
            exp_cnt_q <= exp_cnt_d;
            err_q     <= err_d;
            // Registered copy of (exp_cnt != 0) so the enable is flop-driven.
            for (int i = 0; i < NumIds; i++) release_en_q[i] <= |exp_cnt_d[i];
        end
    end

    always_comb begin
        busy_slots_o = '0;
        for (int s = 0; s < NumSlots; s++) busy_slots_o = busy_slots_o + BusyW'(busy[s]);
    end

    assign release_en_o = release_en_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_simmem_delay_releaser.sv
module tb_simmem_delay_releaser;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_id_i;
    logic [7:0]  req_delay_i;
    logic        rel_done_i;
    logic [3:0]  rel_done_id_i;
    logic [15:0] release_en_o;
    logic [3:0]  busy_slots_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;

    simmem_delay_releaser dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_id_i      (req_id_i),
        .req_delay_i   (req_delay_i),
        .rel_done_i    (rel_done_i),
        .rel_done_id_i (rel_done_id_i),
        .release_en_o  (release_en_o),
        .busy_slots_o  (busy_slots_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_id_i      = '0;
        req_delay_i   = '0;
        rel_done_i    = 1'b0;
        rel_done_id_i = '0;
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rel",   32'(release_en_o), 32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;

        // Idle after reset
        repeat (10) tick();
        chk("idle_rel",   32'(release_en_o), 32'd0);
        chk("idle_ready", 32'(req_ready_o),  32'd1);
        chk("idle_busy",  32'(busy_slots_o), 32'd0);
        chk("idle_err",   32'(err_o),        32'd0);

        // id=3, d=5: accepted at E0, release after E6
        req_valid_i = 1'b1; req_id_i = 4'd3; req_delay_i = 8'd5;
        tick();
        req_valid_i = 1'b0;
        chk("d5_busy", 32'(busy_slots_o), 32'd1);
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk("d5_early", 32'(release_en_o[3]), 32'd0);
        end
        tick();
        chk("d5_rel",      32'(release_en_o), 32'h0008);
        chk("d5_busy_end", 32'(busy_slots_o), 32'd0);
        rel_done_i = 1'b1; rel_done_id_i = 4'd3;
        tick();
        rel_done_i = 1'b0;
        chk("d5_done", 32'(release_en_o), 32'd0);
        chk("d5_err",  32'(err_o),        32'd0);

        // Fill all 8 slots with d=20 (edges A0..A7)
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 1'b1; req_id_i = 4'(i); req_delay_i = 8'd20;
            tick();
        end
        chk("full_ready", 32'(req_ready_o),  32'd0);
        chk("full_busy",  32'(busy_slots_o), 32'd8);
        req_id_i = 4'd9; req_delay_i = 8'd1;   // 9th request, must be refused (A8)
        tick();
        req_valid_i = 1'b0;
        chk("full_9th", 32'(busy_slots_o), 32'd8);
        repeat (12) tick();                    // through A20
        chk("full_pre_exp", 32'(req_ready_o), 32'd0);
        chk("full_no_rel",  32'(release_en_o), 32'd0);
        tick();                                // A21: slot 0 expired
        chk("full_ready_back", 32'(req_ready_o),  32'd1);
        chk("full_rel0",       32'(release_en_o), 32'h0001);
        chk("full_busy7",      32'(busy_slots_o), 32'd7);
        repeat (8) tick();
        chk("full_all_rel", 32'(release_en_o), 32'h00FF);
        for (int i = 0; i < 8; i++) begin
            rel_done_i = 1'b1; rel_done_id_i = 4'(i);
            tick();
        end
        rel_done_i = 1'b0;
        chk("full_drain_rel",  32'(release_en_o), 32'd0);
        chk("full_drain_busy", 32'(busy_slots_o), 32'd0);
        chk("full_drain_err",  32'(err_o),        32'd0);

        // Two id=2 d=0 on consecutive edges, simultaneous expiry + release
        req_valid_i = 1'b1; req_id_i = 4'd2; req_delay_i = 8'd0;
        tick();                                // E0
        chk("dup_e0", 32'(release_en_o), 32'd0);
        tick();                                // E1: first expiry
        req_valid_i = 1'b0;
        chk("dup_e1", 32'(release_en_o), 32'h0004);
        rel_done_i = 1'b1; rel_done_id_i = 4'd2;
        tick();                                // E2: +1 -1
        chk("dup_e2", 32'(release_en_o), 32'h0004);
        tick();                                // E3: -1
        rel_done_i = 1'b0;
        chk("dup_e3",  32'(release_en_o), 32'd0);
        chk("dup_err", 32'(err_o),        32'd0);

        // Underflow: release id=5 with nothing pending
        rel_done_i = 1'b1; rel_done_id_i = 4'd5;
        tick();
        rel_done_i = 1'b0;
        chk("uf_err", 32'(err_o),           32'd1);
        chk("uf_rel", 32'(release_en_o[5]), 32'd0);
        repeat (3) tick();
        chk("uf_sticky", 32'(err_o), 32'd1);

        // Reset mid-flight discards id=1, d=4
        req_valid_i = 1'b1; req_id_i = 4'd1; req_delay_i = 8'd4;
        tick();
        req_valid_i = 1'b0;
        repeat (2) tick();
        chk("mid_busy_pre", 32'(busy_slots_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_busy_async", 32'(busy_slots_o), 32'd0);
        chk("mid_err_async",  32'(err_o),        32'd0);
        tick();
        rst_ni = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("mid_no_rel", 32'(release_en_o[1]), 32'd0);
        end
        chk("mid_busy", 32'(busy_slots_o), 32'd0);
        chk("mid_ready", 32'(req_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
